// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the burst controller and its bus interface.
// The state enum is kept here so the bench and any future wrapper decode the same encoding.
package mem_ctrl_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Address arithmetic wraps at the top of the memory (63 + 1 = 0).
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Host command/data bus plus the memory-side wr/addr/din/dout signals of the burst controller.
// master = host and memory responder side, slave = the controller.
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W,
  parameter int LEN_W  = mem_ctrl_pkg::LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;

  logic              busy;

  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    output mem_dout,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  busy,
    input  mem_wr, mem_addr, mem_din
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    input  mem_dout,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output busy,
    output mem_wr, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller for a 64x8 single-port synchronous memory: one beat per cycle, write beats land
// on mem_* one cycle after handshake, read data returns two cycles after acceptance; rdata has no backpressure.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mem_burst_ctrl_if.slave bus
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [LEN_W-1:0]    beat_cnt;

  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;

  // Two-flop read tracking pipe: stage 0 aligns with mem_addr, stage 1 with mem_dout.
  logic                iss_vld;
  logic                iss_last;
  logic                rd_vld;
  logic                rd_last;

  logic                last_beat;

  assign last_beat = (beat_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      beat_cnt   <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      iss_vld    <= 1'b0;
      iss_last   <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      iss_vld  <= 1'b0;
      iss_last <= 1'b0;
      rd_vld   <= iss_vld;
      rd_last  <= iss_last;

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            mem_addr_q <= bus.cmd_addr;
            beat_cnt   <= bus.cmd_len;
            if (bus.cmd_wr) begin
              addr_cnt <= bus.cmd_addr;
              state    <= WRITE;
            end else begin
              // Beat 0 is issued straight from the command; the counter points at beat 1.
              addr_cnt <= addr_inc(bus.cmd_addr);
              iss_vld  <= 1'b1;
              iss_last <= (bus.cmd_len == '0);
              state    <= READ;
            end
          end
        end

        WRITE: begin
          if (bus.wdata_valid) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= addr_cnt;
            mem_din_q  <= bus.wdata;
            addr_cnt   <= addr_inc(addr_cnt);
            beat_cnt   <= beat_cnt - LEN_W'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end

        READ: begin
          if (last_beat) begin
            state <= DRAIN;
          end else begin
            mem_addr_q <= addr_cnt;
            addr_cnt   <= addr_inc(addr_cnt);
            beat_cnt   <= beat_cnt - LEN_W'(1);
            iss_vld    <= 1'b1;
            iss_last   <= (beat_cnt == LEN_W'(1));
          end
        end

        DRAIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.wdata_ready = (state == WRITE);
  assign bus.busy        = (state != IDLE);

  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;

  assign bus.rdata_valid = rd_vld;
  assign bus.rdata       = bus.mem_dout;
  assign bus.rdata_last  = rd_vld & rd_last;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: directed table of bursts, multi-cycle corner sequences and randomized
// bursts checked against a word-array memory image, with a behavioural 64x8 memory as the responder.
module tb_mem_burst_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_burst_ctrl_if bus ();

  mem_burst_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Responder: single-port synchronous memory, read updates dout only when not writing.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
    else            bus.mem_dout <= mem[bus.mem_addr];
  end

  logic [7:0] refm [64];
  logic [7:0] wbuf [64];
  logic [7:0] rbuf [64];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic           wr;
    logic [5:0]     addr;
    int             len;
    logic [3:0][7:0] d;
    int             gap_after;
    int             gap_len;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [5:0] wrap(input int base, input int off);
    return 6'((base + off) % 64);
  endfunction

  task automatic set_vec(input int idx, input logic wr, input logic [5:0] a, input int len,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input int ga, input int gl);
    tbl[idx].wr = wr;
    tbl[idx].addr = a;
    tbl[idx].len = len;
    tbl[idx].d = {d3, d2, d1, d0};
    tbl[idx].gap_after = ga;
    tbl[idx].gap_len = gl;
  endtask

  // Entered and left at a negedge; on return the block is IDLE in the cycle after the last handshake.
  task automatic do_write(input logic [5:0] a, input int n, input int gap_after, input int gap_len);
    logic [5:0] ea;
    chk("wr_cmd_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = 6'(n - 1);
    cyc();
    bus.cmd_valid = 1'b0;
    chk("wr_busy", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("wr_wdata_ready[%0d]", i), 32'(bus.wdata_ready), 1);
      bus.wdata_valid = 1'b1;
      bus.wdata       = wbuf[i];
      cyc();
      ea = wrap(int'(a), i);
      chk($sformatf("wr_mem_wr[%0d]", i), 32'(bus.mem_wr), 1);
      chk($sformatf("wr_mem_addr[%0d]", i), 32'(bus.mem_addr), 32'(ea));
      chk($sformatf("wr_mem_din[%0d]", i), 32'(bus.mem_din), 32'(wbuf[i]));
      refm[ea] = wbuf[i];
      bus.wdata_valid = 1'b0;
      if (i == gap_after && i < n - 1) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc();
          chk($sformatf("wr_gap_mem_wr[%0d]", g), 32'(bus.mem_wr), 0);
          chk($sformatf("wr_gap_busy[%0d]", g), 32'(bus.busy), 1);
        end
      end
    end
    chk("wr_end_busy", 32'(bus.busy), 0);
    chk("wr_end_cmd_ready", 32'(bus.cmd_ready), 1);
  endtask

  // Cycle-accurate read check against the memory image; captured beats go to rbuf.
  task automatic do_read(input logic [5:0] a, input int n);
    chk("rd_cmd_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = a;
    bus.cmd_len   = 6'(n - 1);
    cyc();
    bus.cmd_valid   = 1'b0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = 8'hEE;
    for (int c = 1; c <= n + 1; c++) begin
      chk($sformatf("rd_busy[%0d]", c), 32'(bus.busy), 1);
      chk($sformatf("rd_cmd_ready[%0d]", c), 32'(bus.cmd_ready), 0);
      chk($sformatf("rd_wdata_ready[%0d]", c), 32'(bus.wdata_ready), 0);
      chk($sformatf("rd_mem_wr[%0d]", c), 32'(bus.mem_wr), 0);
      if (c <= n)
        chk($sformatf("rd_mem_addr[%0d]", c), 32'(bus.mem_addr), 32'(wrap(int'(a), c - 1)));
      chk($sformatf("rd_rdata_valid[%0d]", c), 32'(bus.rdata_valid), 32'(c >= 2));
      if (c >= 2) begin
        rbuf[c-2] = bus.rdata;
        chk($sformatf("rd_rdata[%0d]", c - 2), 32'(bus.rdata), 32'(refm[wrap(int'(a), c - 2)]));
        chk($sformatf("rd_rdata_last[%0d]", c - 2), 32'(bus.rdata_last), 32'(c == n + 1));
      end
      cyc();
    end
    bus.wdata_valid = 1'b0;
    chk("rd_end_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rd_end_busy", 32'(bus.busy), 0);
    chk("rd_end_rdata_valid", 32'(bus.rdata_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] a;
    logic [7:0] exp_r [4];

    for (int i = 0; i < 64; i++) begin
      mem[i]  = 8'h00;
      refm[i] = 8'h00;
    end
    bus.cmd_valid   = 1'b0;
    bus.cmd_wr      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;

    repeat (3) cyc();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_wdata_ready", 32'(bus.wdata_ready), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_din", 32'(bus.mem_din), 0);
    chk("rst_rdata_valid", 32'(bus.rdata_valid), 0);
    chk("rst_rdata_last", 32'(bus.rdata_last), 0);
    reset = 1'b0;
    cyc();

    set_vec(0, 1'b1, 6'd24, 2, 8'hC1, 8'h11, 8'h00, 8'h00, -1, 0);
    set_vec(1, 1'b0, 6'd24, 2, 8'hC1, 8'h11, 8'h00, 8'h00, -1, 0);
    set_vec(2, 1'b1, 6'd62, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, -1, 0);
    set_vec(3, 1'b0, 6'd62, 3, 8'hAA, 8'hBB, 8'hCC, 8'h00, -1, 0);
    set_vec(4, 1'b1, 6'd10, 4, 8'h01, 8'h02, 8'h03, 8'h04,  1, 2);
    set_vec(5, 1'b0, 6'd10, 4, 8'h01, 8'h02, 8'h03, 8'h04, -1, 0);
    set_vec(6, 1'b1, 6'd5,  1, 8'h5A, 8'h00, 8'h00, 8'h00, -1, 0);
    set_vec(7, 1'b0, 6'd5,  1, 8'h5A, 8'h00, 8'h00, 8'h00, -1, 0);

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].wr) begin
        for (int i = 0; i < tbl[v].len; i++) wbuf[i] = tbl[v].d[i];
        do_write(tbl[v].addr, tbl[v].len, tbl[v].gap_after, tbl[v].gap_len);
      end else begin
        do_read(tbl[v].addr, tbl[v].len);
        for (int i = 0; i < tbl[v].len; i++)
          chk($sformatf("tbl%0d_beat%0d", v, i), 32'(rbuf[i]), 32'(tbl[v].d[i]));
      end
      cyc();
    end

    // Read accepted in the cycle right after the last write handshake.
    wbuf[0] = 8'h3C; wbuf[1] = 8'h4D; wbuf[2] = 8'h5E;
    do_write(6'd40, 3, -1, 0);
    do_read(6'd40, 3);
    chk("b2b_beat0", 32'(rbuf[0]), 32'h3C);
    chk("b2b_beat1", 32'(rbuf[1]), 32'h4D);
    chk("b2b_beat2", 32'(rbuf[2]), 32'h5E);

    // Reset in the middle of a 4-beat write, after beats 0 and 1 have been written.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(6'd50, 4, -1, 0);
    cyc();
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 6'd50; bus.cmd_len = 6'd3;
    cyc();
    bus.cmd_valid = 1'b0;
    exp_r[0] = 8'hA0; exp_r[1] = 8'hA1; exp_r[2] = 8'hA2; exp_r[3] = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      bus.wdata_valid = 1'b1;
      bus.wdata = exp_r[i];
      cyc();
      chk($sformatf("rstw_mem_addr[%0d]", i), 32'(bus.mem_addr), 32'(50 + i));
    end
    reset = 1'b1;
    #1;
    chk("rstw_mem_wr", 32'(bus.mem_wr), 0);
    chk("rstw_busy", 32'(bus.busy), 0);
    chk("rstw_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rstw_wdata_ready", 32'(bus.wdata_ready), 0);
    bus.wdata_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    refm[50] = 8'hA0;
    refm[51] = 8'hA1;
    do_read(6'd50, 4);
    chk("rstw_beat0", 32'(rbuf[0]), 32'hA0);
    chk("rstw_beat1", 32'(rbuf[1]), 32'hA1);
    chk("rstw_beat2", 32'(rbuf[2]), 32'h33);
    chk("rstw_beat3", 32'(rbuf[3]), 32'h44);

    // Full-length 64-beat burst starting at the top address.
    for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
    do_write(6'd63, 64, 10, 1);
    do_read(6'd63, 64);
    for (int i = 0; i < 64; i++)
      if (rbuf[i] !== wbuf[i]) chk($sformatf("full_beat%0d", i), 32'(rbuf[i]), 32'(wbuf[i]));
    chk("full_first", 32'(rbuf[0]), 32'(wbuf[0]));
    chk("full_last", 32'(rbuf[63]), 32'(wbuf[63]));

    for (int t = 0; t < 30; t++) begin
      a = 6'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 64)) : int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write(a, n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 3)));
      end else begin
        do_read(a, n);
      end
      repeat ($urandom_range(0, 2)) begin
        bus.wdata_valid = 1'($urandom);
        cyc();
        chk("idle_wdata_ready", 32'(bus.wdata_ready), 0);
        chk("idle_mem_wr", 32'(bus.mem_wr), 0);
      end
      bus.wdata_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst controller that initiates write and read bursts to the team's 64 x 8 single-port synchronous memory. A host issues a command (direction, start address, length), streams write data in or receives read data out, and the block generates the memory's `wr`/`addr`/`din` sequence and captures `dout`. It sits between any data producer/consumer and the memory, so that block is never driven directly.

## Interface
- `ADDR_W`, 6, memory address width (64 words)
- `DATA_W`, 8, memory data width
- `LEN_W`, 6, burst length field; encodes beats minus 1 (1..64 beats)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock, with reset asynchronous and active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  LEN_W  beats minus 1
- `wdata_valid`  in  1  write beat offered
- `wdata_ready`  out  1  high only in WRITE
- `wdata`  in  DATA_W  write beat
- `rdata_valid`  out  1  read beat present; no backpressure, consumer must take it
- `rdata`  out  DATA_W  read beat, equal to `mem_dout`
- `rdata_last`  out  1  final beat of a read burst, qualified by `rdata_valid`
- `busy`  out  1  state != IDLE
- `mem_wr`  out  1  memory write enable, registered
- `mem_addr`  out  ADDR_W  memory address, registered
- `mem_din`  out  DATA_W  memory write data, registered
- `mem_dout`  in  DATA_W  memory read data; the memory updates it on the rising edge from `addr` when `wr`=0

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: `cmd_ready`=1. When `cmd_valid`&`cmd_ready`, latch the address counter from `cmd_addr` and the beat counter from `cmd_len`. Go to WRITE if `cmd_wr`=1, otherwise READ. Also load `mem_addr` from `cmd_addr`.
- WRITE: `wdata_ready`=1. For each handshake, register `mem_wr`=1, `mem_addr`=counter, `mem_din`=`wdata`, then increment the address and decrement the beat counter. When no handshake occurs, `mem_wr` is 0 next cycle (gaps allowed). On the final beat, go to IDLE.
- READ: issue one address per cycle for `cmd_len`+1 cycles with `mem_wr`=0. A 2-stage valid/last shift pipe tracks outstanding beats. After the final issue, go to DRAIN.
- DRAIN: one cycle, covering the last beat's return, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 63 + 1 = 0. The length counter never wraps: `cmd_len`=63 gives 64 beats.
- `wdata_valid` outside WRITE is ignored. `cmd_valid` outside IDLE is not accepted and is held by the host.
- Reset values (asynchronous): state IDLE, `mem_wr`=0, `mem_addr`=0, `mem_din`=0, `rdata_valid`=0, `rdata_last`=0, `busy`=0, `cmd_ready`=1, `wdata_ready`=0. Reset mid-burst abandons the burst immediately and never produces a spurious write. Beats already written remain in memory.

## Timing
- Command accepted in cycle T. WRITE or READ starts in cycle T+1.
- Write beat handshake in cycle k: `mem_wr`/`mem_addr`/`mem_din` are valid during k+1, and the memory writes at the end of k+1. After the last handshake in cycle k, the state is IDLE in k+1, so a new command can be accepted in k+1.
- Read beat i (0-based): `mem_addr` = start+i during cycle T+1+i. `rdata_valid`=1 with the data during T+2+i. `rdata_last` is high during T+1+L, where L = beats.
- Read burst occupancy is L+1 cycles (READ plus DRAIN). `cmd_ready` returns high in T+L+2.
- Minimum write burst is L cycles.

## Structure
- Package `mem_ctrl_pkg`: state enum (IDLE/WRITE/READ/DRAIN), `ADDR_W`/`DATA_W`/`LEN_W` default constants.
- Single module. No sub-module is needed. The read-valid pipe is two flops inline.
- The bench instantiates the existing memory as the responder.

## Test plan
- Write a 2-beat burst at 24 with C1, 11 -> `mem_wr` high for two consecutive cycles, with addr 24/25 and din C1/11.
- Read a 2-beat burst at 24 after the write -> `rdata` C1 at T+2 and 11 at T+3, `rdata_last` at T+3, `cmd_ready` high at T+4.
- Write a 3-beat burst at 62 with AA, BB, CC -> addresses 62, 63, 0. Reading 3 beats at 62 returns AA, BB, CC.
- Write a 4-beat burst with `wdata_valid` dropped for 2 cycles after beat 1 -> `mem_wr` shows a 2-cycle gap, and readback shows no lost or duplicated beats.
- Assert `reset` in the middle of a 4-beat write, after 2 beats -> `mem_wr`=0 and `busy`=0 immediately, `cmd_ready`=1, beats 0 and 1 present in memory, and beats 2 and 3 unwritten.
- Hold `cmd_valid` for a read in the cycle after the last write handshake -> read accepted in that cycle, and the data read equals the just-written values.
